// File: rtl/codec_cfg_seq.sv
// Power-up configuration sequencer for the audio codec: walks a fixed
// 11-entry register table and writes each entry through the shared I2C master.
module codec_cfg_seq #(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter int         BOOT_DELAY     = 1000,
    parameter int         GAP_CYCLES     = 500,
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter int         MAX_RETRY      = 3,
    parameter bit         AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        is_send_o,
    output logic [7:0]  i2c_addr_o,
    output logic [15:0] i2c_data_o,
    input  logic        is_done_i,
    input  logic        is_busy_i,
    output logic        cfg_busy_o,
    output logic        cfg_done_o,
    output logic        cfg_error_o,
    output logic [3:0]  cfg_index_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_LAUNCH,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_e;

    localparam int CNT_MAX = (BOOT_DELAY > GAP_CYCLES) ? BOOT_DELAY : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_DELAY - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [17:0]      TMO_LAST   = 18'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_INDEX = 4'd10;

    function automatic logic [15:0] tableEntry(input logic [3:0] idx);
        logic [15:0] word;
        case (idx)
            4'd0:    word = 16'h1E00;
            4'd1:    word = 16'h0C00;
            4'd2:    word = 16'h0017;
            4'd3:    word = 16'h0217;
            4'd4:    word = 16'h0479;
            4'd5:    word = 16'h0679;
            4'd6:    word = 16'h0812;
            4'd7:    word = 16'h0A00;
            4'd8:    word = 16'h0E02;
            4'd9:    word = 16'h1000;
            4'd10:   word = 16'h1201;
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       index_q, index_d;
    logic [1:0]       retry_q, retry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [17:0]      tmo_q, tmo_d;
    logic             okay_q, okay_d;
    logic [15:0]      data_q, data_d;
    logic             isSend_q;
    logic             cfgBusy_q;
    logic             cfgDone_q;
    logic             cfgError_q;
    logic             busySync_q, busyPrev_q;
    logic             doneSync_q, donePrev_q;

    logic        busyFall;
    logic        doneRise;
    logic        tmoHit;
    logic [17:0] tmoNext;
    logic        fail;
    logic        restart;

    assign busyFall = busyPrev_q & ~busySync_q;
    assign doneRise = doneSync_q & ~donePrev_q;
    assign tmoHit   = (tmo_q >= TMO_LAST);
    assign tmoNext  = (tmo_q == 18'h3FFFF) ? tmo_q : tmo_q + 18'd1;

    // Next-state logic; a done rise is checked before NACK/timeout so simultaneous events count as success
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        okay_d  = okay_q;
        data_d  = data_q;
        fail    = 1'b0;
        restart = 1'b0;

        case (state_q)
            S_BOOT: begin
                if (busySync_q) begin
                    cnt_d = '0;
                end else if (cnt_q == BOOT_LAST) begin
                    cnt_d = '0;
                    if (AUTO_START) begin
                        restart = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    restart = 1'b1;
                end
            end
            S_LAUNCH: begin
                if (!busySync_q) begin
                    tmo_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                tmo_d = tmoNext;
                if (busySync_q) begin
                    state_d = S_WAIT;
                end else if (tmoHit) begin
                    fail = 1'b1;
                end
            end
            S_WAIT: begin
                tmo_d = tmoNext;
                if (doneRise) begin
                    okay_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (busyFall || tmoHit) begin
                    fail = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (!okay_q) begin
                        state_d = S_LAUNCH;
                    end else if (index_q == LAST_INDEX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                        retry_d = '0;
                        state_d = S_LAUNCH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (fail) begin
            retry_d = retry_q + 2'd1;
            okay_d  = 1'b0;
            cnt_d   = '0;
            state_d = ((int'(retry_q) + 1) < MAX_RETRY) ? S_GAP : S_ERROR;
        end

        if (restart) begin
            state_d = S_LAUNCH;
            index_d = '0;
            retry_d = '0;
            cnt_d   = '0;
        end

        // The write word is latched only while launching, so it holds through REQ and WAIT
        if (state_d == S_LAUNCH) begin
            data_d = tableEntry(index_d);
        end
    end

    // Master handshake is assumed busy until proven otherwise, since the master has no reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            index_q    <= '0;
            retry_q    <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            okay_q     <= 1'b0;
            data_q     <= 16'h0000;
            isSend_q   <= 1'b0;
            cfgBusy_q  <= 1'b0;
            cfgDone_q  <= 1'b0;
            cfgError_q <= 1'b0;
            busySync_q <= 1'b1;
            busyPrev_q <= 1'b1;
            doneSync_q <= 1'b0;
            donePrev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            retry_q    <= retry_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            okay_q     <= okay_d;
            data_q     <= data_d;
            isSend_q   <= (state_d == S_REQ);
            cfgBusy_q  <= (state_d == S_LAUNCH) || (state_d == S_REQ) ||
                          (state_d == S_WAIT) || (state_d == S_GAP);
            cfgDone_q  <= (state_d == S_DONE);
            cfgError_q <= (state_d == S_ERROR);
            busySync_q <= is_busy_i;
            busyPrev_q <= busySync_q;
            doneSync_q <= is_done_i;
            donePrev_q <= doneSync_q;
        end
    end

    assign is_send_o   = isSend_q;
    assign i2c_addr_o  = DEV_ADDR;
    assign i2c_data_o  = data_q;
    assign cfg_busy_o  = cfgBusy_q;
    assign cfg_done_o  = cfgDone_q;
    assign cfg_error_o = cfgError_q;
    assign cfg_index_o = index_q;

endmodule

// File: doc/codec_cfg_seq.md
Name: codec_cfg_seq

Overview:
- Power-up configuration sequencer for the audio codec feeding the FIR filter datapath.
- Walks a fixed 11-entry register table and issues one 16-bit write per entry through the shared I2C master's is_send / is_done / is_busy handshake.
- Detects NACK and timeout, retries each entry a bounded number of times, and reports done or error to the system.

Parameters:
- DEV_ADDR, 8'h34, 8-bit I2C address byte driven on i2c_addr (7-bit 0x1A, write).
- BOOT_DELAY, 1000, clk cycles after reset release before the first write.
- GAP_CYCLES, 500, idle clk cycles between the end of one transaction and the next launch.
- TIMEOUT_CYCLES, 200000, max clk cycles from launch to the is_done rising edge.
- MAX_RETRY, 3, attempts per entry, including the first.
- AUTO_START, 1, 1 = start the sequence after BOOT_DELAY; 0 = wait for start.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; restarts the sequence from entry 0 when in IDLE, DONE or ERROR. Ignored otherwise.
- is_send, output, 1, launch request to the I2C master.
- i2c_addr, output, 8, constant DEV_ADDR.
- i2c_data, output, 16, {reg[6:0], val[8:0]} of the current entry.
- is_done, input, 1, I2C master completion level (wide pulse).
- is_busy, input, 1, I2C master busy level.
- cfg_busy, output, 1, sequence in progress.
- cfg_done, output, 1, all 11 entries acknowledged; held until next start or reset.
- cfg_error, output, 1, an entry exhausted MAX_RETRY; held until next start or reset.
- cfg_index, output, 4, current or last entry index.

Behaviour:
- Reset (async, any state): state = BOOT; is_send = 0, i2c_data = 16'h0000, cfg_busy = 0, cfg_done = 0, cfg_error = 0, cfg_index = 0; all counters cleared. The I2C master has no reset, so it may still be busy; handled in BOOT.
- Table, fixed, index 0..10:
  - 0 = 16'h1E00 (reset)
  - 1 = 16'h0C00 (power)
  - 2 = 16'h0017
  - 3 = 16'h0217
  - 4 = 16'h0479
  - 5 = 16'h0679
  - 6 = 16'h0812
  - 7 = 16'h0A00
  - 8 = 16'h0E02
  - 9 = 16'h1000
  - 10 = 16'h1201 (activate)
- is_done and is_busy are registered once internally. Edges are detected on the registered copies.
- States:
  - BOOT: count BOOT_DELAY cycles with is_busy low throughout; the count restarts while is_busy = 1. At terminal count go to LAUNCH if AUTO_START, else IDLE.
  - IDLE: cfg_busy = 0. start -> LAUNCH with index = 0, retry = 0, cfg_done = 0, cfg_error = 0.
  - LAUNCH: cfg_busy = 1. i2c_data = table[index]. Wait for is_busy = 0, then assert is_send and clear the timeout counter. Go to REQ.
  - REQ: hold is_send = 1 until is_busy = 1 is seen; the master samples only once per SCL period. Then drop is_send and go to WAIT. The timeout counter runs.
  - WAIT, success: is_done rising edge -> go to GAP.
  - WAIT, failure: an is_busy falling edge with no is_done rise in this transaction (NACK), or timeout expiry in REQ or WAIT. On failure, retry++. If retry < MAX_RETRY go to GAP, then LAUNCH the same index. Otherwise go to ERROR.
  - GAP: wait GAP_CYCLES. Then:
    - after a success with index = 10 -> DONE;
    - after another success -> index++, retry = 0, LAUNCH;
    - after a failure -> LAUNCH the same index.
  - DONE: cfg_done = 1, cfg_busy = 0; start -> LAUNCH from 0.
  - ERROR: cfg_error = 1, cfg_busy = 0, cfg_index frozen at the failing entry; start -> LAUNCH from 0.
- Outputs:
  - is_send is never asserted outside REQ.
  - i2c_data is stable from LAUNCH until exit from WAIT.
  - cfg_done and cfg_error are never high together.
- Simultaneous events:
  - An is_done rise and an is_busy fall in the same cycle count as success.
  - A timeout and is_done in the same cycle count as success.
  - start in any state other than IDLE, DONE or ERROR is ignored.
- Timeout counter is 18 bits and saturates. Retry counter is 2 bits.

Test Plan:
- AUTO_START = 1, slave ACKs everything -> exactly 11 is_send launches with i2c_data in order 1E00, 0C00, 0017, 0217, 0479, 0679, 0812, 0A00, 0E02, 1000, 1201; i2c_addr = 8'h34; cfg_done = 1, cfg_index = 10, cfg_error = 0.
- Slave NACKs entry 4 once -> 0479 is sent twice, then the sequence completes. Total 12 launches, cfg_done = 1.
- Slave NACKs entry 2 always -> 0017 is sent 3 times; cfg_error = 1, cfg_index = 2, no further is_send. Then a start pulse with ACKs -> full 11-write run and cfg_done = 1.
- Slave model holds is_busy high with no is_done (TIMEOUT_CYCLES = 5000) -> retry after 5000 cycles; after 3 attempts cfg_error = 1.
- rst_n low mid-transaction at entry 6 while the master is busy -> outputs return to reset values immediately. After release, no is_send until is_busy = 0 plus BOOT_DELAY, then the sequence restarts at 1E00.
- AUTO_START = 0 -> is_send stays 0 for 10000 cycles. A start pulse begins the run; a start pulse during the run has no effect on the launch sequence.
